// File: rtl/rabbit_g_engine.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// rabbit_g_engine : multi-lane Rabbit g-function, MULT_UNITS squarers shared
//                   across LANES words per request (valid/ready both sides)
// Revision: 1.0
// =============================================================================
module rabbit_g_engine #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 8,
    parameter int MULT_UNITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_state,
    input  logic [LANES*WIDTH-1:0]   in_counter,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_g,
    output logic                     busy
);

    localparam int BEATS  = LANES / MULT_UNITS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if ((LANES % MULT_UNITS) != 0) begin : g_bad_mult_units
            $error("rabbit_g_engine: LANES must be a multiple of MULT_UNITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t                    r_fsm;
    fsm_t                    w_fsm_next;
    logic [BEAT_W-1:0]       r_beat;
    logic [LANES*WIDTH-1:0]  r_opd_state;
    logic [LANES*WIDTH-1:0]  r_opd_counter;
    logic [MULT_UNITS*WIDTH-1:0] w_unit_g;
    logic                    w_accept;

    assign w_accept = (r_fsm == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE: if (in_valid) w_fsm_next = S_BUSY;
            S_BUSY: if (r_beat == LAST_BEAT) w_fsm_next = S_DONE;
            S_DONE: if (out_ready) w_fsm_next = S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // Operands are captured once so the upstream side may move on during BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opd_state   <= '0;
            r_opd_counter <= '0;
            r_beat        <= '0;
        end else if (w_accept) begin
            r_opd_state   <= in_state;
            r_opd_counter <= in_counter;
            r_beat        <= '0;
        end else if (r_fsm == S_BUSY) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    // Squarer j serves lanes j, j+MULT_UNITS, j+2*MULT_UNITS, ... in beat order.
    generate
        for (genvar j = 0; j < MULT_UNITS; j++) begin : g_unit
            logic [WIDTH-1:0]   w_sel_state;
            logic [WIDTH-1:0]   w_sel_counter;
            logic [WIDTH-1:0]   w_u;
            logic [2*WIDTH-1:0] w_sq;

            always_comb begin
                w_sel_state   = '0;
                w_sel_counter = '0;
                for (int b = 0; b < BEATS; b++) begin
                    if (r_beat == BEAT_W'(b)) begin
                        w_sel_state   = r_opd_state[(b*MULT_UNITS + j)*WIDTH +: WIDTH];
                        w_sel_counter = r_opd_counter[(b*MULT_UNITS + j)*WIDTH +: WIDTH];
                    end
                end
            end

            assign w_u  = w_sel_counter + w_sel_state;
            assign w_sq = {{WIDTH{1'b0}}, w_u} * {{WIDTH{1'b0}}, w_u};
            assign w_unit_g[j*WIDTH +: WIDTH] = w_sq[2*WIDTH-1:WIDTH] ^ w_sq[WIDTH-1:0];
        end
    endgenerate

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam int UNIT = i % MULT_UNITS;
            localparam logic [BEAT_W-1:0] LANE_BEAT = BEAT_W'(i / MULT_UNITS);

            logic [WIDTH-1:0] r_lane_g;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane_g <= '0;
                end else if ((r_fsm == S_BUSY) && (r_beat == LANE_BEAT)) begin
                    r_lane_g <= w_unit_g[UNIT*WIDTH +: WIDTH];
                end
            end

            assign out_g[i*WIDTH +: WIDTH] = r_lane_g;
        end
    endgenerate

    // in_ready is gated by rst_n so it stays low for the whole reset interval.
    assign in_ready  = rst_n && (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rabbit_g_engine.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_rabbit_g_engine : randomized bench with a behavioural g-function model
// Revision: 1.0
// =============================================================================
module tb_rabbit_g_engine;

    localparam int W     = 32;
    localparam int L     = 8;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_g(input logic [63:0] c, input logic [63:0] s, input int w);
        logic [63:0] mask, u, sq;
        mask = (64'd1 << w) - 64'd1;
        u    = (c + s) & mask;
        sq   = u * u;
        return ((sq >> w) ^ sq) & mask;
    endfunction

    function automatic logic [255:0] g_vec(input logic [255:0] s, input logic [255:0] c);
        logic [255:0] r;
        logic [63:0]  t;
        r = '0;
        for (int i = 0; i < L; i++) begin
            t = ref_g(64'(c[i*W +: W]), 64'(s[i*W +: W]), W);
            r[i*W +: W] = t[W-1:0];
        end
        return r;
    endfunction

    function automatic int cfg_w(input int c);   return (c == 2) ? 16 : 32; endfunction
    function automatic int cfg_l(input int c);   return (c == 2) ? 4 : 8;   endfunction
    function automatic int cfg_mu(input int c);  return (c == 0) ? 8 : 2;   endfunction
    function automatic int cfg_lat(input int c); return (c == 0) ? 2 : ((c == 1) ? 5 : 3); endfunction

    // ---------------- main instance (default parameters) ----------------
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [255:0] in_state = '0;
    logic [255:0] in_counter = '0;
    logic         in_ready, out_valid, busy;
    logic [255:0] out_g;

    rabbit_g_engine #(.WIDTH(W), .LANES(L), .MULT_UNITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_counter (in_counter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_g      (out_g),
        .busy       (busy)
    );

    // Model: a request occupies the engine for BEATS cycles, then waits for the consumer.
    int           m_cnt   = 0;
    bit           m_done  = 1'b0;
    bit           m_clear = 1'b1;
    logic [255:0] m_g     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_done  <= 1'b0;
            m_clear <= 1'b1;
            m_g     <= '0;
        end else if (m_cnt == 0 && !m_done) begin
            if (in_valid) begin
                m_g     <= g_vec(in_state, in_counter);
                m_cnt   <= BEATS;
                m_clear <= 1'b0;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 256'(in_ready), 256'(rst_n && m_cnt == 0 && !m_done));
        chk("out_valid", 256'(out_valid), 256'(m_done));
        chk("busy", 256'(busy), 256'(m_cnt > 0 || m_done));
        if (m_done) chk("out_g", out_g, m_g);
        else if (m_clear) chk("out_g_cleared", out_g, '0);
    end

    int acc_cyc = 0;

    task automatic send(input logic [255:0] s, input logic [255:0] c);
        in_state   = s;
        in_counter = c;
        in_valid   = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        chk("accept", 256'(in_ready), 256'(1));
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        for (int t = 0; t < 64; t++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("out_valid_seen", 256'(out_valid), 256'(1));
        lat = cyc - acc_cyc;
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // ---------------- parameter sweep instances ----------------
    generate
        for (genvar c = 0; c < 3; c++) begin : g_sweep
            localparam int SW   = cfg_w(c);
            localparam int SL   = cfg_l(c);
            localparam int SM   = cfg_mu(c);
            localparam int SB   = SL / SM;
            localparam int SLAT = cfg_lat(c);

            logic              s_rst_n = 1'b0;
            logic              s_iv = 1'b0;
            logic              s_or = 1'b1;
            logic [SL*SW-1:0]  s_st = '0;
            logic [SL*SW-1:0]  s_ct = '0;
            logic [SL*SW-1:0]  s_g;
            logic              s_ir, s_ov, s_busy;
            logic              s_done = 1'b0;

            rabbit_g_engine #(.WIDTH(SW), .LANES(SL), .MULT_UNITS(SM)) u_dut (
                .clk        (clk),
                .rst_n      (s_rst_n),
                .in_valid   (s_iv),
                .in_ready   (s_ir),
                .in_state   (s_st),
                .in_counter (s_ct),
                .out_valid  (s_ov),
                .out_ready  (s_or),
                .out_g      (s_g),
                .busy       (s_busy)
            );

            initial begin
                int               acc, prev;
                logic [SL*SW-1:0] s_exp;
                logic [63:0]      t;
                acc  = 0;
                prev = 0;
                repeat (2) @(negedge clk);
                @(posedge clk);
                #2 s_rst_n = 1'b1;
                @(negedge clk);
                for (int r = 0; r < 6; r++) begin
                    for (int i = 0; i < SL; i++) begin
                        s_st[i*SW +: SW] = SW'($urandom);
                        s_ct[i*SW +: SW] = SW'($urandom);
                        t = ref_g(64'(s_ct[i*SW +: SW]), 64'(s_st[i*SW +: SW]), SW);
                        s_exp[i*SW +: SW] = t[SW-1:0];
                    end
                    s_iv = 1'b1;
                    for (int k = 0; k < 64; k++) begin
                        if (s_ir) break;
                        @(negedge clk);
                    end
                    chk($sformatf("sweep%0d_accept", c), 256'(s_ir), 256'(1));
                    acc = cyc;
                    @(negedge clk);
                    s_iv = 1'b0;
                    for (int k = 0; k < 64; k++) begin
                        if (s_ov) break;
                        @(negedge clk);
                    end
                    chk($sformatf("sweep%0d_valid", c), 256'(s_ov), 256'(1));
                    chk($sformatf("sweep%0d_latency", c), 256'(cyc - acc), 256'(SLAT));
                    chk($sformatf("sweep%0d_g", c), 256'(s_g), 256'(s_exp));
                    if (r > 0) chk($sformatf("sweep%0d_interval", c), 256'(acc - prev), 256'(SB + 2));
                    prev = acc;
                end
                @(negedge clk);
                s_done = 1'b1;
            end
        end
    endgenerate

    // ---------------- main directed + random sequence ----------------
    initial begin
        logic [255:0] s, c;
        int           lat;
        bit           all_done;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_g", out_g, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 256'(in_ready), 256'(1));

        // Identity: u = 1 in every lane.
        for (int i = 0; i < L; i++) begin
            s[i*W +: W] = 32'h1;
            c[i*W +: W] = 32'h0;
        end
        send(s, c);
        wait_valid(lat);
        chk("identity_latency", 256'(lat), 256'(9));
        chk("identity_g", out_g, {8{32'h0000_0001}});
        @(negedge clk);

        // Wrap and half-split lanes amid random ones.
        s = rand_vec();
        c = rand_vec();
        c[31:0]    = 32'hFFFF_FFFF; s[31:0]    = 32'h0;
        c[127:96]  = 32'hFFFF_FFFF; s[127:96]  = 32'h1;
        c[191:160] = 32'h0000_8000; s[191:160] = 32'h0000_8000;
        send(s, c);
        wait_valid(lat);
        chk("wrap_lane0", 256'(out_g[31:0]), 256'(32'hFFFF_FFFF));
        chk("wrap_lane3", 256'(out_g[127:96]), 256'(32'h0));
        chk("half_lane5", 256'(out_g[191:160]), 256'(32'h1));
        chk("mixed_all", out_g, g_vec(s, c));
        @(negedge clk);

        // Backpressure: result must be held for 20 cycles.
        out_ready = 1'b0;
        s = rand_vec();
        c = rand_vec();
        send(s, c);
        wait_valid(lat);
        repeat (20) @(negedge clk);
        chk("bp_in_ready", 256'(in_ready), 256'(0));
        chk("bp_out_valid", 256'(out_valid), 256'(1));
        chk("bp_g", out_g, g_vec(s, c));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 256'(out_valid), 256'(0));
        chk("bp_release_ready", 256'(in_ready), 256'(1));

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_state   = rand_vec();
            in_counter = rand_vec();
            out_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (BEATS + 4) @(negedge clk);

        // Asynchronous reset at beat 4.
        s = rand_vec();
        c = rand_vec();
        send(s, c);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_out_g", out_g, '0);
        chk("arst_busy", 256'(busy), 256'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        s = rand_vec();
        c = rand_vec();
        send(s, c);
        wait_valid(lat);
        chk("post_rst_latency", 256'(lat), 256'(9));
        chk("post_rst_g", out_g, g_vec(s, c));
        @(negedge clk);

        all_done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            all_done = g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done;
            if (all_done) break;
            @(negedge clk);
        end
        chk("sweep_done", 256'(all_done), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
